// File: rtl/mem_io_pkg.sv
// Shared constants for the data-side memory/MMIO unit: RV32 size codes, MMIO map, FSM states.
package mem_io_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [31:0] MMIO_SEG   = 32'h0000_0000;
   localparam logic [31:0] MMIO_UDATA = 32'h0000_0004;
   localparam logic [31:0] MMIO_USTAT = 32'h0000_0008;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RX_WAIT = 2'd1,
      TX_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/mem_io_unit_load_align.sv
// Load lane selection and sign/zero extension from a 32-bit RAM word.
module mem_load_align
   import mem_io_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = rdata[{addr_lo, 3'b000} +: 8];
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   data = {{24{lane_b[7]}}, lane_b};
         F3_LBU:  data = {24'b0, lane_b};
         F3_LH:   data = {{16{lane_h[15]}}, lane_h};
         F3_LHU:  data = {16'b0, lane_h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_io_unit.sv
// Data-side RAM + MMIO unit: store lanes, misalign detection, UART status and blocking UART RX/TX.
//
// state   | meaning
// IDLE    | accept loads/stores, single-cycle RAM and MMIO handling
// RX_WAIT | UART data read pending on empty RX FIFO, pipeline stalled
// TX_WAIT | UART data write pending on full TX FIFO, pipeline stalled
module mem_io_unit
   import mem_io_pkg::*;
#(
   parameter int          RAM_AW     = 15,
   parameter int          SEG_W      = 16,
   parameter logic [31:0] SEG_ADDR   = MMIO_SEG,
   parameter logic [31:0] UDATA_ADDR = MMIO_UDATA,
   parameter logic [31:0] USTAT_ADDR = MMIO_USTAT,
   parameter bit          UART_BLOCK = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       writedata,
   input  logic              writectrl,
   input  logic              readctrl,
   output logic [31:0]       readdata,
   output logic              stall,
   output logic              misalign,
   input  logic [31:0]       addr_inst,
   output logic [31:0]       readdata_inst,
   output logic [RAM_AW-1:0] ram_addr_a,
   input  logic [31:0]       ram_rdata_a,
   output logic [RAM_AW-1:0] ram_addr_b,
   output logic [31:0]       ram_wdata_b,
   output logic [3:0]        ram_be_b,
   output logic              ram_we_b,
   input  logic [31:0]       ram_rdata_b,
   input  logic [7:0]        rx_data,
   input  logic              rx_empty,
   output logic              rx_rdreq,
   output logic [7:0]        tx_data,
   input  logic              tx_full,
   output logic              tx_wrreq,
   output logic [SEG_W-1:0]  seg_io
);

   state_t      state, state_nx;
   logic        is_seg, is_udata, is_ustat, is_mmio;
   logic        idle, wr_req, rd_req;
   logic        st_mis, ld_mis, mis_nx;
   logic [3:0]  be;
   logic        ld_ram, src_ram;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [31:0] cap_q, cap_nx, align_data;
   logic        cap_en, stall_c, rx_rd_c, tx_wr_c, seg_we;
   logic        unused_addr_inst;

   assign ram_addr_a       = addr_inst[RAM_AW+1:2];
   assign readdata_inst    = ram_rdata_a;
   assign unused_addr_inst = ^{addr_inst[31:RAM_AW+2], addr_inst[1:0]};

   assign is_seg   = (addr == SEG_ADDR);
   assign is_udata = (addr == UDATA_ADDR);
   assign is_ustat = (addr == USTAT_ADDR);
   assign is_mmio  = is_seg | is_udata | is_ustat;

   assign idle   = (state == IDLE);
   assign wr_req = idle & writectrl;
   assign rd_req = idle & readctrl & ~writectrl;

   always_comb begin
      be          = 4'b0000;
      st_mis      = 1'b0;
      ram_wdata_b = writedata;
      case (funct3)
         F3_SB: begin
            be          = 4'b0001 << addr[1:0];
            ram_wdata_b = {4{writedata[7:0]}};
         end
         F3_SH: begin
            be          = addr[1] ? 4'b1100 : 4'b0011;
            st_mis      = addr[0];
            ram_wdata_b = {2{writedata[15:0]}};
         end
         F3_SW: begin
            be     = 4'b1111;
            st_mis = (addr[1:0] != 2'b00);
         end
         default: ;
      endcase
   end

   always_comb begin
      case (funct3)
         F3_LH, F3_LHU: ld_mis = addr[0];
         F3_LW:         ld_mis = (addr[1:0] != 2'b00);
         default:       ld_mis = 1'b0;
      endcase
   end

   assign ram_addr_b = addr[RAM_AW+1:2];
   assign ram_be_b   = be;
   assign ram_we_b   = rst_n & wr_req & ~is_mmio & ~st_mis & (be != 4'b0000);
   assign tx_data    = writedata[7:0];
   assign ld_ram     = rd_req & ~is_mmio & ~ld_mis;
   assign seg_we     = wr_req & is_seg & ~st_mis;
   assign mis_nx     = (wr_req & st_mis) | (rd_req & ld_mis);

   mem_load_align u_align (
      .funct3  (f3_q),
      .addr_lo (lo_q),
      .rdata   (ram_rdata_b),
      .data    (align_data)
   );

   always_comb begin
      state_nx = state;
      stall_c  = 1'b0;
      rx_rd_c  = 1'b0;
      tx_wr_c  = 1'b0;
      cap_en   = 1'b0;
      cap_nx   = 32'h0;
      case (state)
         IDLE: begin
            if (wr_req && is_udata && !st_mis) begin
               if (!tx_full) begin
                  tx_wr_c = 1'b1;
               end else if (UART_BLOCK) begin
                  stall_c  = 1'b1;
                  state_nx = TX_WAIT;
               end
            end else if (rd_req && (is_mmio || ld_mis)) begin
               cap_en = 1'b1;
               if (ld_mis || is_seg) begin
                  cap_nx = 32'h0;
               end else if (is_ustat) begin
                  cap_nx = {30'b0, tx_full, ~rx_empty};
               end else if (!rx_empty) begin
                  rx_rd_c = 1'b1;
                  cap_nx  = {24'b0, rx_data};
               end else if (UART_BLOCK) begin
                  cap_en   = 1'b0;
                  stall_c  = 1'b1;
                  state_nx = RX_WAIT;
               end else begin
                  cap_nx = 32'hFFFF_FFFF;
               end
            end
         end
         RX_WAIT: begin
            stall_c = rx_empty;
            if (!rx_empty) begin
               rx_rd_c  = 1'b1;
               cap_en   = 1'b1;
               cap_nx   = {24'b0, rx_data};
               state_nx = IDLE;
            end
         end
         TX_WAIT: begin
            stall_c = tx_full;
            if (!tx_full) begin
               tx_wr_c  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Gated by rst_n so a reset mid-wait releases the pipe without waiting for an edge.
   assign stall    = stall_c & rst_n;
   assign rx_rdreq = rx_rd_c & rst_n;
   assign tx_wrreq = tx_wr_c & rst_n;

   // RAM results are folded into cap_q one cycle later so readdata holds while the RAM address moves.
   assign readdata = src_ram ? align_data : cap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         misalign <= 1'b0;
         src_ram  <= 1'b0;
         f3_q     <= 3'b0;
         lo_q     <= 2'b0;
         cap_q    <= 32'h0;
         seg_io   <= '0;
      end else begin
         state    <= state_nx;
         misalign <= mis_nx;
         src_ram  <= ld_ram;
         if (ld_ram) begin
            f3_q <= funct3;
            lo_q <= addr[1:0];
         end
         if (src_ram) cap_q <= align_data;
         if (cap_en)  cap_q <= cap_nx;
         if (seg_we)  seg_io <= writedata[SEG_W-1:0];
      end
   end

endmodule
